wave_table_engine: RTL
======================

# wave_table_engine

Parametrised wave-table playback channel for the APU. It succeeds the single-bank 4-bit wave RAM: storage is internal, sample width is configurable, and there are two banks with CPU/playback bank separation and an optional 64-step dual-bank mode. It also adds an 11-bit period counter, position sequencing and a volume shifter. It sits between the APU register decode (CPU port) and the channel mixer/DAC (`sample_out`).

## Interface
Parameters:
- `SAMPLE_BITS`, 4: bits per sample. Only 4 or 8 are legal. With 4, high nibble plays first.
- `BANK_BYTES`, 16: bytes per bank. Must be a power of two, ≥2.
- Derived `SPB` = BANK_BYTES*8/SAMPLE_BITS, samples per bank. `PW` = log2(2*SPB), position width.

Ports:
- `apu_4mhz`  in  1  sole clock; all state on rising edge.
- `napu_reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  log2(BANK_BYTES)  byte address within CPU-visible bank.
- `cpu_wr`  in  1  write strobe, one byte per cycle.
- `cpu_rd`  in  1  read strobe.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  registered read data.
- `ch_enable`  in  1  channel DAC/playback enable.
- `trigger`  in  1  one-cycle restart pulse.
- `freq`  in  11  period value; period = 2048 − freq clocks.
- `bank_sel`  in  1  playback bank; CPU sees !bank_sel.
- `dual_bank`  in  1  play both banks as one 2*SPB sequence.
- `vol_code`  in  2  0 = mute, 1 = full, 2 = >>1, 3 = >>2.
- `sample_out`  out  SAMPLE_BITS  scaled current sample.
- `sample_strobe`  out  1  one-cycle pulse when `sample_out` takes a new fetched sample.
- `position`  out  PW  current sample index.

## Operation
- **Storage:** 2×BANK_BYTES bytes, not reset (contents undefined until written).
- **CPU access:**
  - Always targets bank !bank_sel at `cpu_addr`.
  - A write commits at the clock edge.
  - A read loads `cpu_rdata` at the clock edge; `cpu_rdata` holds otherwise.
  - `cpu_wr` and `cpu_rd` together: write performed, read ignored, `cpu_rdata` holds.
- **Period counter (11 bit):**
  - `trigger` loads `freq`.
  - While `ch_enable` is high it increments each clock. At 2047 it reloads `freq` and issues an advance.
  - While `ch_enable` is low the counter is frozen.
- **Advance:** position ← position+1.
  - Single mode: wraps at SPB−1 → 0 and uses only the low log2(SPB) bits; MSB is forced to 0.
  - Dual mode: wraps at 2*SPB−1 → 0. Playback bank = bank_sel XOR position MSB.
- **Fetch:** the byte holding the new position is read into the sample buffer on the same edge as the advance.
  - SAMPLE_BITS = 4: position LSB 0 selects bits [7:4], LSB 1 selects [3:0].
- **Output register:** `sample_out` = buffer sample >> (vol_code−1), or 0 for vol_code 0. Registered; `vol_code` changes appear one clock later even without an advance.
- **Trigger:**
  - Position ← 0 and counter ← `freq`.
  - No fetch: the buffer keeps its last sample, so the first advance after a trigger plays position 1.
  - Acts regardless of `ch_enable`.
- **`ch_enable` low:** `sample_out` = 0 (registered); buffer and position retained.

## Timing
- **Reset values:** counter 0, position 0, buffer 0, `sample_out` 0, `sample_strobe` 0, `cpu_rdata` 0.
- **Advance edge E (counter 2047→reload):** position and buffer update at E. `sample_out` and `sample_strobe`=1 appear at E+1. Strobe is high for exactly one cycle.
- **Period:** with freq = F, advances are 2048−F clocks apart. freq = 2047 gives an advance every clock, with back-to-back strobes.
- **`freq` changes:** take effect at the next reload, not mid-count.
- **Same-cycle collisions:**
  - CPU write to the byte being fetched: the fetch gets old data.
  - `trigger` with an advance: trigger wins, no fetch, no strobe.
- **`bank_sel` change:** affects the next fetch and the next CPU access; no restart.
- **`dual_bank` cleared mid-play:** the position MSB drops on the next advance.
- **Reset asserted mid-operation:** all registers clear immediately; RAM is untouched.
- **Read latency:** `cpu_rdata` is valid 1 clock after `cpu_rd`.

## Test plan
All scenarios use default parameters.
- **CPU access:** write bank 1 (bank_sel=0) bytes 0..15 = 0x01,0x23,…,0xEF, then read back → `cpu_rdata` matches one clock after each `cpu_rd`. Writes never alter bank 0 contents as later seen by playback.
- **Playback order:** preload bank 0 with bytes 0x01,0x23,…,0xEF; freq=2046, vol 1, trigger, enable → strobes every 2 clocks; `sample_out` sequence 1,2,3,…,15,0,1 (wrap after position 31).
- **Volume:** buffer sample 0xC with vol_code 2 → 6; vol_code 3 → 3; vol_code 0 → 0. Each change appears one clock after `vol_code` changes.
- **Dual bank:** bank 0 filled with nibble 0x5, bank 1 with 0xA, dual_bank=1, freq=2047 → positions 1..31 give 5, positions 32..63 give A, then 0 gives 5.
- **Trigger collision:** trigger coincident with counter=2047 → no strobe, position 0, `sample_out` unchanged. The next advance fetches position 1.
- **Reset mid-play:** reset asserted mid-play → all outputs 0 asynchronously; after release, CPU reads return pre-reset RAM contents.

Source files
------------

// File: rtl/wave_table_engine_if.sv
// CPU register-port bundle for the wave-table engine: byte address, strobes and data.
interface wave_table_engine_if #(
  parameter int BANK_BYTES = 16
) ();
  localparam int AW = $clog2(BANK_BYTES);

  logic [AW-1:0] cpu_addr;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;

  modport master (
    output cpu_addr, cpu_wr, cpu_rd, cpu_wdata,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_addr, cpu_wr, cpu_rd, cpu_wdata,
    output cpu_rdata
  );
endinterface

// File: rtl/wave_table_engine.sv
// Two-bank wave-table playback channel: period counter, position sequencer, fetch and volume shift.
// Latency: sample_out/sample_strobe 1 clk after the advance edge, cpu_rdata 1 clk after cpu_rd; no backpressure.
module wave_table_engine #(
  parameter  int SAMPLE_BITS = 4,
  parameter  int BANK_BYTES  = 16,
  localparam int SPB         = BANK_BYTES * 8 / SAMPLE_BITS,
  localparam int PW          = $clog2(2 * SPB)
) (
  input  logic                   apu_4mhz,
  input  logic                   napu_reset,
  wave_table_engine_if.slave     cpu,
  input  logic                   ch_enable,
  input  logic                   trigger,
  input  logic [10:0]            freq,
  input  logic                   bank_sel,
  input  logic                   dual_bank,
  input  logic [1:0]             vol_code,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic                   sample_strobe,
  output logic [PW-1:0]          position
);
  localparam int AW = $clog2(BANK_BYTES);

  logic [7:0]             mem [2*BANK_BYTES];
  logic [10:0]            period_cnt;
  logic [PW-1:0]          pos_q;
  logic [PW-1:0]          pos_nxt;
  logic [SAMPLE_BITS-1:0] sample_buf;
  logic [SAMPLE_BITS-1:0] fetch_sample;
  logic [SAMPLE_BITS-1:0] scaled;
  logic                   advance;
  logic                   adv_q;
  logic                   play_bank;
  logic [AW-1:0]          fetch_idx;
  logic [7:0]             fetch_byte;
  logic [AW:0]            cpu_idx;

  // Trigger has priority over a coincident reload: no advance, no fetch.
  assign advance = ch_enable && !trigger && (period_cnt == 11'h7FF);

  always_comb begin
    pos_nxt = '0;
    if (dual_bank) begin
      pos_nxt = pos_q + 1'b1;
    end else begin
      pos_nxt = {1'b0, pos_q[PW-2:0] + 1'b1};
    end
  end

  assign play_bank  = bank_sel ^ pos_nxt[PW-1];
  assign fetch_byte = mem[{play_bank, fetch_idx}];
  assign cpu_idx    = {~bank_sel, cpu.cpu_addr};

  generate
    if (SAMPLE_BITS == 4) begin : g_nibble
      assign fetch_idx    = pos_nxt[AW:1];
      assign fetch_sample = pos_nxt[0] ? fetch_byte[3:0] : fetch_byte[7:4];
    end else begin : g_byte
      assign fetch_idx    = pos_nxt[AW-1:0];
      assign fetch_sample = fetch_byte;
    end
  endgenerate

  always_comb begin
    scaled = '0;
    case (vol_code)
      2'd1:    scaled = sample_buf;
      2'd2:    scaled = sample_buf >> 1;
      2'd3:    scaled = sample_buf >> 2;
      default: scaled = '0;
    endcase
  end

  // Wave RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge apu_4mhz) begin
    if (cpu.cpu_wr) begin
      mem[cpu_idx] <= cpu.cpu_wdata;
    end
  end

  always_ff @(posedge apu_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      period_cnt    <= '0;
      pos_q         <= '0;
      sample_buf    <= '0;
      adv_q         <= 1'b0;
      sample_strobe <= 1'b0;
      sample_out    <= '0;
      cpu.cpu_rdata <= '0;
    end else begin
      if (trigger) begin
        period_cnt <= freq;
        pos_q      <= '0;
      end else if (ch_enable) begin
        if (period_cnt == 11'h7FF) begin
          period_cnt <= freq;
          pos_q      <= pos_nxt;
          sample_buf <= fetch_sample;
        end else begin
          period_cnt <= period_cnt + 11'd1;
        end
      end

      adv_q         <= advance;
      sample_strobe <= adv_q;
      sample_out    <= ch_enable ? scaled : '0;

      if (cpu.cpu_rd && !cpu.cpu_wr) begin
        cpu.cpu_rdata <= mem[cpu_idx];
      end
    end
  end

  assign position = pos_q;
endmodule
